// File: rtl/ps2_keyboard_pkg.sv
// Shared types and constants for the PS/2 keyboard receiver.
package ps2_keyboard_pkg;

  // Frame layout: start, 8 data bits (LSB first), odd parity, stop.
  localparam int unsigned DataBits = 8;

  // Default deglitch depth and partial-frame timeout (2 ms at 25 MHz).
  localparam int unsigned DefaultFilter  = 8;
  localparam int unsigned DefaultTimeout = 50000;

  // Receive FSM states.
  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StData   = 2'd1,
    StParity = 2'd2,
    StStop   = 2'd3
  } ps2_state_e;

  // Odd parity holds when data bits plus the parity bit have an odd number of ones.
  function automatic logic odd_parity_ok(input logic [DataBits-1:0] b, input logic p);
    return ^{b, p};
  endfunction

endpackage

// File: rtl/ps2_keyboard_filter.sv
// Two-flop synchroniser followed by a stability counter: the filtered level
// only follows the pin after FILTER consecutive equal synchronised samples.
module ps2_keyboard_filter #(
  parameter int unsigned FILTER = 8
) (
  input  logic clock,
  input  logic reset,
  input  logic raw,
  output logic level
);

  localparam int unsigned CntW = (FILTER > 1) ? $clog2(FILTER) : 1;

  logic          sync1_q, sync2_q;
  logic          level_q, level_d;
  logic [CntW-1:0] cnt_q, cnt_d;

  // Synchroniser chain; idle PS/2 lines are high, so reset to 1.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
    end else begin
      sync1_q <= raw;
      sync2_q <= sync1_q;
    end
  end

  // Count samples that disagree with the accepted level; flip on the FILTER-th.
  always_comb begin
    level_d = level_q;
    cnt_d   = '0;
    if (sync2_q != level_q) begin
      if (cnt_q == CntW'(FILTER - 1)) begin
        level_d = sync2_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  // Filter state register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      level_q <= 1'b1;
      cnt_q   <= '0;
    end else begin
      level_q <= level_d;
      cnt_q   <= cnt_d;
    end
  end

  assign level = level_q;

endmodule

// File: rtl/ps2_keyboard.sv
// PS/2 device-to-host receiver: deglitches the pins, deserialises 11-bit
// frames, checks framing and odd parity, and queues good bytes in a FIFO.
module ps2_keyboard
  import ps2_keyboard_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 16,
  parameter int unsigned FILTER     = DefaultFilter,
  parameter int unsigned TIMEOUT    = DefaultTimeout
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          ps2_clk,
  input  logic                          ps2_dat,
  input  logic                          rd,
  output logic [7:0]                    data,
  output logic                          ready,
  output logic [$clog2(FIFO_DEPTH):0]   count,
  output logic                          overflow,
  output logic                          frame_err,
  input  logic                          clr_err
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned TW = $clog2(TIMEOUT + 1);

  logic clk_f, dat_f, clk_f_prev_q, sample;

  ps2_keyboard_filter #(.FILTER(FILTER)) u_clk_filter (
    .clock (clock),
    .reset (reset),
    .raw   (ps2_clk),
    .level (clk_f)
  );

  ps2_keyboard_filter #(.FILTER(FILTER)) u_dat_filter (
    .clock (clock),
    .reset (reset),
    .raw   (ps2_dat),
    .level (dat_f)
  );

  // Remember the previous filtered clock to find its falling edge.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) clk_f_prev_q <= 1'b1;
    else       clk_f_prev_q <= clk_f;
  end

  assign sample = clk_f_prev_q & ~clk_f;

  ps2_state_e    state_q, state_d;
  logic [2:0]    bit_cnt_q, bit_cnt_d;
  logic [7:0]    shift_q, shift_d;
  logic          par_q, par_d;
  logic [TW-1:0] to_cnt_q, to_cnt_d;
  logic          push, err_set;

  // Frame FSM next-state, timeout supervision, push and error strobes.
  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    par_d     = par_q;
    to_cnt_d  = '0;
    push      = 1'b0;
    err_set   = 1'b0;

    if (state_q != StIdle && !sample && to_cnt_q == TW'(TIMEOUT - 1)) begin
      // Line went quiet mid-frame: drop the partial byte.
      err_set = 1'b1;
      state_d = StIdle;
    end else begin
      if (state_q != StIdle && !sample) to_cnt_d = to_cnt_q + 1'b1;
      unique case (state_q)
        StIdle: begin
          if (sample) begin
            if (!dat_f) begin
              state_d   = StData;
              bit_cnt_d = '0;
            end else begin
              err_set = 1'b1;
            end
          end
        end
        StData: begin
          if (sample) begin
            shift_d   = {dat_f, shift_q[7:1]};
            bit_cnt_d = bit_cnt_q + 1'b1;
            if (bit_cnt_q == 3'(DataBits - 1)) state_d = StParity;
          end
        end
        StParity: begin
          if (sample) begin
            par_d   = dat_f;
            state_d = StStop;
          end
        end
        StStop: begin
          if (sample) begin
            if (dat_f && odd_parity_ok(shift_q, par_q)) push = 1'b1;
            else                                         err_set = 1'b1;
            state_d = StIdle;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  // Frame FSM state register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= StIdle;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      par_q     <= 1'b0;
      to_cnt_q  <= '0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      par_q     <= par_d;
      to_cnt_q  <= to_cnt_d;
    end
  end

  logic [7:0]  mem_q [FIFO_DEPTH];
  logic [AW:0] wr_ptr_q, rd_ptr_q;
  logic        empty, full, do_pop, do_push, ovf_set;

  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign do_pop  = rd & ~empty;
  // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
  assign do_push = push & (~full | do_pop);
  assign ovf_set = push & full & ~do_pop;

  // FIFO storage and pointers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      for (int i = 0; i < int'(FIFO_DEPTH); i++) mem_q[i] <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q[AW-1:0]] <= shift_q;
        wr_ptr_q                <= wr_ptr_q + 1'b1;
      end
      if (do_pop) rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  // Sticky error flags; a same-cycle new error beats clr_err.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      overflow  <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      overflow  <= ovf_set | (overflow & ~clr_err);
      frame_err <= err_set | (frame_err & ~clr_err);
    end
  end

  assign data  = mem_q[rd_ptr_q[AW-1:0]];
  assign ready = ~empty;
  assign count = wr_ptr_q - rd_ptr_q;

endmodule

// File: tb/tb_ps2_keyboard.sv
// Scoreboard bench for ps2_keyboard: the stimulus process serialises random
// frames and queues the bytes a PS/2 receiver must deliver; a monitor pops
// the DUT FIFO and compares against that queue.
module tb_ps2_keyboard;

  localparam int unsigned Depth   = 16;
  localparam int unsigned Filt    = 8;
  localparam int unsigned Tmo     = 1000;
  localparam int          Half    = 20;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       ps2_clk = 1'b1;
  logic       ps2_dat = 1'b1;
  logic       rd = 1'b0;
  logic       clr_err = 1'b0;
  logic [7:0] data;
  logic       ready;
  logic [4:0] count;
  logic       overflow;
  logic       frame_err;

  ps2_keyboard #(.FIFO_DEPTH(Depth), .FILTER(Filt), .TIMEOUT(Tmo)) dut (
    .clock     (clock),
    .reset     (reset),
    .ps2_clk   (ps2_clk),
    .ps2_dat   (ps2_dat),
    .rd        (rd),
    .data      (data),
    .ready     (ready),
    .count     (count),
    .overflow  (overflow),
    .frame_err (frame_err),
    .clr_err   (clr_err)
  );

  always #5 clock = ~clock;

  int         n_checks = 0;
  int         n_pass   = 0;
  logic [7:0] exp_q[$];
  bit         reader_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clock);
  endtask

  // Frame as sent on the wire, bit 0 first: start, data LSB first, parity, stop.
  function automatic logic [10:0] make_frame(input logic [7:0] b, input bit bad_par,
                                             input bit bad_stop);
    logic p;
    p = (~^b) ^ bad_par;
    return {~bad_stop, p, b, 1'b0};
  endfunction

  // Send the first nbits of a frame; optionally a short low glitch on ps2_clk.
  task automatic send_bits(input logic [10:0] bits, input int nbits, input int glitch_bit);
    for (int i = 0; i < nbits; i++) begin
      ps2_dat = bits[i];
      wait_clk(Half);
      ps2_clk = 1'b0;
      wait_clk(Half);
      ps2_clk = 1'b1;
      if (i == glitch_bit) begin
        wait_clk(8);
        ps2_clk = 1'b0;
        wait_clk(3);
        ps2_clk = 1'b1;
        wait_clk(Half - 11);
      end else begin
        wait_clk(Half);
      end
    end
    ps2_dat = 1'b1;
  endtask

  // Full frame plus reference model: good frames are queued (or counted as overflow
  // when the model FIFO is full), bad ones only raise the expected error.
  task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop,
                            input int glitch_bit, inout bit exp_err, inout bit exp_ovf);
    send_bits(make_frame(b, bad_par, bad_stop), 11, glitch_bit);
    if (bad_par || bad_stop) exp_err = 1'b1;
    else if (exp_q.size() < Depth) exp_q.push_back(b);
    else exp_ovf = 1'b1;
  endtask

  task automatic pulse_clr();
    clr_err = 1'b1;
    wait_clk(1);
    clr_err = 1'b0;
    wait_clk(1);
  endtask

  task automatic drain(input string name);
    int t;
    t = 0;
    while (exp_q.size() != 0 && t < 3000) begin
      wait_clk(1);
      t++;
    end
    wait_clk(4);
    check({name, "_drained"}, 32'(exp_q.size()), 32'd0);
    check({name, "_ready"}, 32'(ready), 32'd0);
    check({name, "_count"}, 32'(count), 32'd0);
  endtask

  // Monitor: pops the DUT head at random moments and compares with the scoreboard.
  initial begin
    forever begin
      @(negedge clock);
      rd = 1'b0;
      if (reader_en && ready && exp_q.size() != 0 && $urandom_range(0, 3) == 0) begin
        check("fifo_data", 32'(data), 32'(exp_q.pop_front()));
        rd = 1'b1;
      end
    end
  end

  initial begin
    bit         e_err;
    bit         e_ovf;
    logic [7:0] b;
    int         kind;

    e_err = 1'b0;
    e_ovf = 1'b0;
    wait_clk(3);
    check("rst_data", 32'(data), 32'd0);
    check("rst_ready", 32'(ready), 32'd0);
    check("rst_count", 32'(count), 32'd0);
    check("rst_overflow", 32'(overflow), 32'd0);
    check("rst_frame_err", 32'(frame_err), 32'd0);
    reset = 1'b0;
    wait_clk(3);

    // Single 0x1C, then 0xF0/0x1C back to back, observed before any pop.
    send_frame(8'h1C, 0, 0, -1, e_err, e_ovf);
    check("a_ready", 32'(ready), 32'd1);
    check("a_data", 32'(data), 32'h1C);
    check("a_count", 32'(count), 32'd1);
    check("a_frame_err", 32'(frame_err), 32'd0);
    reader_en = 1'b1;
    drain("a");
    reader_en = 1'b0;
    send_frame(8'hF0, 0, 0, -1, e_err, e_ovf);
    send_frame(8'h1C, 0, 0, -1, e_err, e_ovf);
    check("b_count", 32'(count), 32'd2);
    check("b_head", 32'(data), 32'hF0);
    reader_en = 1'b1;
    drain("b");

    // Bad start bit: a lone falling edge with data high.
    send_bits(11'h001, 1, -1);
    wait_clk(4);
    check("start_err", 32'(frame_err), 32'd1);
    pulse_clr();
    check("start_err_clr", 32'(frame_err), 32'd0);

    // Stall after the start bit and four data bits, then a clean 0x29.
    send_bits(make_frame(8'h5A, 0, 0), 5, -1);
    wait_clk(Tmo + 50);
    check("timeout_err", 32'(frame_err), 32'd1);
    check("timeout_ready", 32'(ready), 32'd0);
    e_err = 1'b1;
    send_frame(8'h29, 0, 0, -1, e_err, e_ovf);
    check("timeout_err_held", 32'(frame_err), 32'(e_err));
    pulse_clr();
    e_err = 1'b0;
    drain("t");

    // Random traffic: good, bad parity, bad stop, and glitched frames.
    for (int n = 0; n < 30; n++) begin
      b    = 8'($urandom);
      kind = int'($urandom_range(0, 9));
      send_frame(b, kind == 0, kind == 1, (kind == 2) ? int'($urandom_range(1, 9)) : -1,
                 e_err, e_ovf);
      wait_clk(4);
      check("rand_frame_err", 32'(frame_err), 32'(e_err));
      if (e_err) begin
        pulse_clr();
        e_err = 1'b0;
        check("rand_err_clr", 32'(frame_err), 32'd0);
      end
    end
    drain("r");

    // Overflow: 17 frames with the reader parked.
    reader_en = 1'b0;
    for (int n = 0; n < 17; n++) send_frame(8'($urandom), 0, 0, -1, e_err, e_ovf);
    wait_clk(4);
    check("ovf_count", 32'(count), 32'(exp_q.size()));
    check("ovf_flag", 32'(overflow), 32'(e_ovf));
    check("ovf_frame_err", 32'(frame_err), 32'd0);
    pulse_clr();
    check("ovf_clr", 32'(overflow), 32'd0);
    reader_en = 1'b1;
    drain("o");

    // Reset in the middle of a frame; the next frame starts cleanly.
    reader_en = 1'b0;
    send_frame(8'h33, 0, 0, -1, e_err, e_ovf);
    send_bits(make_frame(8'hA5, 0, 0), 5, -1);
    reset = 1'b1;
    exp_q.delete();
    wait_clk(2);
    check("midrst_ready", 32'(ready), 32'd0);
    check("midrst_count", 32'(count), 32'd0);
    reset = 1'b0;
    wait_clk(2);
    send_frame(8'h66, 0, 0, -1, e_err, e_ovf);
    check("midrst_data", 32'(data), 32'h66);
    check("midrst_frame_err", 32'(frame_err), 32'd0);
    reader_en = 1'b1;
    drain("m");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
